// File: rtl/mmac_job_sequencer.sv
// mmac_job_sequencer: steps the MAC through clear, N operand tiles and a held result hand-off.
module mmac_job_sequencer #(
    parameter int MAX_TILES = 256,
    parameter int CNT_W     = $clog2(MAX_TILES + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [CNT_W-1:0] job_tiles,
    input  logic             abort,
    input  logic             op_valid,
    output logic             op_ready,
    output logic             mac_enable,
    output logic             mac_clear,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy,
    output logic [CNT_W-1:0] tiles_done
);
    typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, DONE, FLUSH} state_t;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] target_q, target_d, tiles_done_q, tiles_done_d;
    logic             in_job;
    assign in_job     = state_q == CLEAR || state_q == ACCUM || state_q == DONE;
    assign job_ready  = state_q == IDLE;
    assign busy       = state_q != IDLE;
    // abort wins over any handshake in the same cycle
    assign op_ready   = state_q == ACCUM && !abort;
    assign mac_enable = op_ready && op_valid;
    assign mac_clear  = state_q == CLEAR || state_q == FLUSH;
    assign res_valid  = state_q == DONE && !abort;
    assign tiles_done = tiles_done_q;
    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        tiles_done_d = tiles_done_q;
        case (state_q)
            IDLE: if (job_valid) begin
                state_d      = CLEAR;
                target_d     = job_tiles > CNT_W'(MAX_TILES) ? CNT_W'(MAX_TILES) : job_tiles;
                tiles_done_d = '0;
            end
            CLEAR: state_d = target_q == '0 ? DONE : ACCUM;
            ACCUM: if (mac_enable) begin
                tiles_done_d = tiles_done_q + CNT_W'(1);
                state_d      = tiles_done_q + CNT_W'(1) == target_q ? DONE : ACCUM;
            end
            DONE: state_d = res_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
        if (abort && in_job) begin
            state_d      = FLUSH;
            tiles_done_d = '0;
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            target_q     <= '0;
            tiles_done_q <= '0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            tiles_done_q <= tiles_done_d;
        end
    end
endmodule
